// File: rtl/time_setter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// time_setter_if : button, running-time and edited-time bundle | rev 1.0
// ---------------------------------------------------------------------------
interface time_setter_if;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic        btn_ok;
  logic [15:0] cur_year;
  logic [5:0]  cur_month;
  logic [10:0] cur_day;
  logic [10:0] cur_week;
  logic [10:0] cur_hour;
  logic [10:0] cur_minute;
  logic [10:0] cur_second;
  logic [15:0] set_year;
  logic [5:0]  set_month;
  logic [10:0] set_day;
  logic [10:0] set_week;
  logic [10:0] set_hour;
  logic [10:0] set_minute;
  logic [10:0] set_second;
  logic        load;
  logic        editing;
  logic [2:0]  field_sel;

  modport master (
    output btn_mode, btn_up, btn_down, btn_ok,
    output cur_year, cur_month, cur_day, cur_week, cur_hour, cur_minute, cur_second,
    input  set_year, set_month, set_day, set_week, set_hour, set_minute, set_second,
    input  load, editing, field_sel
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, btn_ok,
    input  cur_year, cur_month, cur_day, cur_week, cur_hour, cur_minute, cur_second,
    output set_year, set_month, set_day, set_week, set_hour, set_minute, set_second,
    output load, editing, field_sel
  );
endinterface
`default_nettype wire

// File: rtl/time_setter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// time_setter : button-driven date/time editor issuing a load strobe | rev 1.0
// Optional idle auto-abort: define TIME_SETTER_TIMEOUT_EN
// ---------------------------------------------------------------------------
module time_setter #(
  parameter int YEAR_MIN       = 2000,
  parameter int YEAR_MAX       = 2099,
  parameter int TIMEOUT_CYCLES = 30_000_000
) (
  input wire           clk,
  input wire           rst_n,
  time_setter_if.slave bus
);

  localparam logic [15:0] C_YEAR_MIN = 16'(YEAR_MIN);
  localparam logic [15:0] C_YEAR_MAX = 16'(YEAR_MAX);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EDIT = 2'd1, S_COMMIT = 2'd2} state_t;

  state_t      state_q;
  logic [15:0] year_q,   year_d;
  logic [5:0]  month_q,  month_d;
  logic [10:0] day_q,    day_d;
  logic [10:0] week_q,   week_d;
  logic [10:0] hour_q,   hour_d;
  logic [10:0] minute_q, minute_d;
  logic [10:0] second_q, second_d;
  logic [2:0]  field_sel_q;
  logic        load_q;
  logic        editing_q;
  logic        w_timeout;

  function automatic logic [15:0] f_step(input logic [15:0] v, input logic [15:0] lo,
                                         input logic [15:0] hi, input logic up);
    if (up) f_step = (v >= hi) ? lo : v + 16'd1;
    else    f_step = (v <= lo) ? hi : v - 16'd1;
  endfunction

  function automatic logic [15:0] f_clamp(input logic [15:0] v, input logic [15:0] lo,
                                          input logic [15:0] hi);
    f_clamp = (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [15:0] f_dim(input logic [5:0] m, input logic [15:0] y);
    logic leap;
    leap = (y % 16'd4 == 16'd0) && ((y % 16'd100 != 16'd0) || (y % 16'd400 == 16'd0));
    case (m)
      6'd2:                      f_dim = leap ? 16'd29 : 16'd28;
      6'd4, 6'd6, 6'd9, 6'd11:   f_dim = 16'd30;
      default:                   f_dim = 16'd31;
    endcase
  endfunction

  // Snapshot of the running time, forced into legal ranges
  logic [15:0] w_ent_year;
  logic [5:0]  w_ent_month;
  logic [10:0] w_ent_day, w_ent_week, w_ent_hour, w_ent_minute, w_ent_second;

  assign w_ent_year   = f_clamp(bus.cur_year, C_YEAR_MIN, C_YEAR_MAX);
  assign w_ent_month  = 6'(f_clamp({10'd0, bus.cur_month}, 16'd1, 16'd12));
  assign w_ent_day    = 11'(f_clamp({5'd0, bus.cur_day}, 16'd1, f_dim(w_ent_month, w_ent_year)));
  assign w_ent_week   = 11'(f_clamp({5'd0, bus.cur_week}, 16'd1, 16'd7));
  assign w_ent_hour   = 11'(f_clamp({5'd0, bus.cur_hour}, 16'd0, 16'd23));
  assign w_ent_minute = 11'(f_clamp({5'd0, bus.cur_minute}, 16'd0, 16'd59));
  assign w_ent_second = 11'(f_clamp({5'd0, bus.cur_second}, 16'd0, 16'd59));

  logic        w_up;
  logic        w_step_en;
  logic [15:0] w_year_step;
  logic [5:0]  w_month_step;
  logic [15:0] w_dim_cur, w_dim_ystep, w_dim_mstep;

  assign w_up         = bus.btn_up;
  assign w_step_en    = (state_q == S_EDIT) && !bus.btn_ok && !bus.btn_mode &&
                        (bus.btn_up ^ bus.btn_down);
  assign w_year_step  = f_step(year_q, C_YEAR_MIN, C_YEAR_MAX, w_up);
  assign w_month_step = 6'(f_step({10'd0, month_q}, 16'd1, 16'd12, w_up));
  assign w_dim_cur    = f_dim(month_q, year_q);
  assign w_dim_ystep  = f_dim(month_q, w_year_step);
  assign w_dim_mstep  = f_dim(w_month_step, year_q);

  always_comb begin
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    week_d   = week_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    if (state_q == S_IDLE && bus.btn_mode) begin
      year_d   = w_ent_year;
      month_d  = w_ent_month;
      day_d    = w_ent_day;
      week_d   = w_ent_week;
      hour_d   = w_ent_hour;
      minute_d = w_ent_minute;
      second_d = w_ent_second;
    end else if (w_step_en) begin
      case (field_sel_q)
        3'd0: begin
          year_d = w_year_step;
          if ({5'd0, day_q} > w_dim_ystep) day_d = 11'(w_dim_ystep);
        end
        3'd1: begin
          month_d = w_month_step;
          if ({5'd0, day_q} > w_dim_mstep) day_d = 11'(w_dim_mstep);
        end
        3'd2:    day_d    = 11'(f_step({5'd0, day_q}, 16'd1, w_dim_cur, w_up));
        3'd3:    week_d   = 11'(f_step({5'd0, week_q}, 16'd1, 16'd7, w_up));
        3'd4:    hour_d   = 11'(f_step({5'd0, hour_q}, 16'd0, 16'd23, w_up));
        3'd5:    minute_d = 11'(f_step({5'd0, minute_q}, 16'd0, 16'd59, w_up));
        3'd6:    second_d = 11'(f_step({5'd0, second_q}, 16'd0, 16'd59, w_up));
        default: ;
      endcase
    end
  end

`ifdef TIME_SETTER_TIMEOUT_EN
  localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic               w_any_btn;
  logic [C_CNT_W-1:0] idle_cnt_q;

  assign w_any_btn = bus.btn_mode | bus.btn_up | bus.btn_down | bus.btn_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             idle_cnt_q <= '0;
    else if (state_q != S_EDIT || w_any_btn) idle_cnt_q <= '0;
    else                                    idle_cnt_q <= idle_cnt_q + 1'b1;
  end

  assign w_timeout = (state_q == S_EDIT) && !w_any_btn &&
                     (idle_cnt_q == C_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the abort feature the timeout parameter has no effect
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      year_q      <= C_YEAR_MIN;
      month_q     <= 6'd1;
      day_q       <= 11'd1;
      week_q      <= 11'd1;
      hour_q      <= 11'd0;
      minute_q    <= 11'd0;
      second_q    <= 11'd0;
      field_sel_q <= 3'd0;
      load_q      <= 1'b0;
      editing_q   <= 1'b0;
    end else begin
      year_q   <= year_d;
      month_q  <= month_d;
      day_q    <= day_d;
      week_q   <= week_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      load_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.btn_mode) begin
            state_q     <= S_EDIT;
            editing_q   <= 1'b1;
            field_sel_q <= 3'd0;
          end
        end
        S_EDIT: begin
          if (bus.btn_ok) begin
            state_q   <= S_COMMIT;
            load_q    <= 1'b1;
            editing_q <= 1'b0;
          end else if (bus.btn_mode) begin
            field_sel_q <= (field_sel_q == 3'd6) ? 3'd0 : field_sel_q + 3'd1;
          end else if (w_timeout) begin
            state_q   <= S_IDLE;
            editing_q <= 1'b0;
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        default: begin
          state_q   <= S_IDLE;
          editing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.set_year   = year_q;
  assign bus.set_month  = month_q;
  assign bus.set_day    = day_q;
  assign bus.set_week   = week_q;
  assign bus.set_hour   = hour_q;
  assign bus.set_minute = minute_q;
  assign bus.set_second = second_q;
  assign bus.load       = load_q;
  assign bus.editing    = editing_q;
  assign bus.field_sel  = field_sel_q;

endmodule
`default_nettype wire
